// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: drives the integer register file write port from two
// sources, the single-cycle pipeline writeback and a long-latency
// (load/MDU) unit with a valid/ready handshake. The pipeline normally wins.
// A starvation counter forces the long-latency result through after it has
// waited STARVE_MAX cycles. A 32-entry pending-write scoreboard produces
// RAW (hazard_stall) and WAW (issue_stall) stalls for decode.
// Optional feature macro: WB_BYPASS_EN. When it is defined, the module adds
// the byp1_hit/byp2_hit/byp_data outputs. These let decode forward the
// register file write that is still in flight instead of stalling for it.
module regfile_wb_ctrl #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_rd,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_stall,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_stall,
  input  logic [4:0]  src1_addr,
  input  logic [4:0]  src2_addr,
  output logic        hazard_stall,
  output logic [31:0] pending,
`ifdef WB_BYPASS_EN
  output logic        byp1_hit,
  output logic        byp2_hit,
  output logic [31:0] byp_data,
`endif
  output logic [4:0]  w_reg_addr,
  output logic [31:0] w_data,
  output logic        RegWrite
);

  localparam logic [CNT_W-1:0] LP_STARVE = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_pending;
  logic [4:0]       r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_wr_en;

  logic             w_starve;
  logic             w_pipe_acc;
  logic             w_ll_ready;
  logic             w_ll_acc;
  logic             w_issue_stall;
  logic             w_set;
  logic [31:0]      w_pend_nxt;
  logic             w_wb_hit1;
  logic             w_wb_hit2;
  logic             w_h1;
  logic             w_h2;

  // Arbitration: pipeline has priority unless the long-latency result is starved
  assign w_starve   = ll_valid && (r_cnt == LP_STARVE);
  assign w_pipe_acc = pipe_wb_valid && !w_starve;
  assign w_ll_ready = !pipe_wb_valid || w_starve;
  assign w_ll_acc   = ll_valid && w_ll_ready;

  assign pipe_stall = w_starve && pipe_wb_valid;
  assign ll_ready   = w_ll_ready;

  // WAW check and scoreboard set use the scoreboard as it stands before the edge
  assign w_issue_stall = issue_valid && (issue_rd != 5'd0) && r_pending[issue_rd];
  assign w_set         = issue_valid && !w_issue_stall && (issue_rd != 5'd0);
  assign issue_stall   = w_issue_stall;

  // Next scoreboard: clear on long-latency accept, then set on issue so set wins
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_ll_acc) begin
      w_pend_nxt[ll_rd] = 1'b0;
    end
    if (w_set) begin
      w_pend_nxt[issue_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  // Match against the register file write that is not yet visible to a read
  assign w_wb_hit1 = r_wr_en && (r_wr_addr == src1_addr) && (src1_addr != 5'd0);
  assign w_wb_hit2 = r_wr_en && (r_wr_addr == src2_addr) && (src2_addr != 5'd0);

`ifdef WB_BYPASS_EN
  assign w_h1     = (src1_addr != 5'd0) && r_pending[src1_addr];
  assign w_h2     = (src2_addr != 5'd0) && r_pending[src2_addr];
  assign byp1_hit = w_wb_hit1;
  assign byp2_hit = w_wb_hit2;
  assign byp_data = r_wr_data;
`else
  assign w_h1 = ((src1_addr != 5'd0) && r_pending[src1_addr]) || w_wb_hit1;
  assign w_h2 = ((src2_addr != 5'd0) && r_pending[src2_addr]) || w_wb_hit2;
`endif

  assign hazard_stall = w_h1 || w_h2;
  assign pending      = r_pending;
  assign w_reg_addr   = r_wr_addr;
  assign w_data       = r_wr_data;
  assign RegWrite     = r_wr_en;

  // Starvation counter: counts cycles a valid long-latency result is refused
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!ll_valid || w_ll_acc) begin
      r_cnt <= '0;
    end else if (r_cnt != LP_STARVE) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Pending-write scoreboard
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nxt;
    end
  end

  // Registered write port: capture the winner, never enable a write to x0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
    end else if (w_pipe_acc) begin
      r_wr_addr <= pipe_wb_rd;
      r_wr_data <= pipe_wb_data;
      r_wr_en   <= (pipe_wb_rd != 5'd0);
    end else if (w_ll_acc) begin
      r_wr_addr <= ll_rd;
      r_wr_data <= ll_data;
      r_wr_en   <= (ll_rd != 5'd0);
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl (STARVE_MAX=4). Builds with or without
// WB_BYPASS_EN; the RAW scenario's expectations follow the macro.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        reset;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [4:0]  src1_addr;
  logic [4:0]  src2_addr;
  logic        hazard_stall;
  logic [31:0] pending;
  logic [4:0]  w_reg_addr;
  logic [31:0] w_data;
  logic        RegWrite;
`ifdef WB_BYPASS_EN
  logic        byp1_hit;
  logic        byp2_hit;
  logic [31:0] byp_data;
`endif

  int total = 0;
  int bad   = 0;

  regfile_wb_ctrl #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .pipe_wb_valid(pipe_wb_valid),
    .pipe_wb_rd   (pipe_wb_rd),
    .pipe_wb_data (pipe_wb_data),
    .pipe_stall   (pipe_stall),
    .ll_valid     (ll_valid),
    .ll_rd        (ll_rd),
    .ll_data      (ll_data),
    .ll_ready     (ll_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_stall  (issue_stall),
    .src1_addr    (src1_addr),
    .src2_addr    (src2_addr),
    .hazard_stall (hazard_stall),
    .pending      (pending),
`ifdef WB_BYPASS_EN
    .byp1_hit     (byp1_hit),
    .byp2_hit     (byp2_hit),
    .byp_data     (byp_data),
`endif
    .w_reg_addr   (w_reg_addr),
    .w_data       (w_data),
    .RegWrite     (RegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_wb_valid = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    src1_addr = '0; src2_addr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();
    // populate state before reset
    issue_valid = 1'b1; issue_rd = 5'd7;
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'hAA;
    step();
    idle();
    #1;
    total++; if (pending !== 32'h0000_0080) begin bad++; $display("FAIL pre_reset_pending got=%h exp=%h", pending, 32'h80); end
    total++; if (w_reg_addr !== 5'd5) begin bad++; $display("FAIL pre_reset_addr got=%0d exp=5", w_reg_addr); end
    // async assertion mid-cycle
    #1 reset = 1'b0;
    #1;
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL async_pending got=%h exp=0", pending); end
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL async_regwrite got=%b exp=0", RegWrite); end
    total++; if (w_reg_addr !== 5'd0) begin bad++; $display("FAIL async_addr got=%0d exp=0", w_reg_addr); end
    total++; if (w_data !== 32'h0) begin bad++; $display("FAIL async_data got=%h exp=0", w_data); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL post_reset_pending got=%h exp=0", pending); end
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL post_reset_regwrite got=%b exp=0", RegWrite); end
    total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL post_reset_pipe_stall got=%b exp=0", pipe_stall); end
  endtask

  task automatic test_pipe_write();
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'hDEAD_BEEF;
    #1;
    total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL pw_pipe_stall got=%b exp=0", pipe_stall); end
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL pw_ll_ready got=%b exp=0", ll_ready); end
    step();
    idle();
    #1;
    total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL pw_regwrite got=%b exp=1", RegWrite); end
    total++; if (w_reg_addr !== 5'd5) begin bad++; $display("FAIL pw_addr got=%0d exp=5", w_reg_addr); end
    total++; if (w_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pw_data got=%h exp=deadbeef", w_data); end
    step();
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL pw_regwrite_drop got=%b exp=0", RegWrite); end
    total++; if (w_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL pw_data_hold got=%h exp=deadbeef", w_data); end
  endtask

  task automatic test_x0();
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd0; pipe_wb_data = 32'h1234;
    issue_valid = 1'b1; issue_rd = 5'd0;
    #1;
    total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL x0_issue_stall got=%b exp=0", issue_stall); end
    step();
    idle();
    #1;
    total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL x0_regwrite got=%b exp=0", RegWrite); end
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL x0_pending got=%h exp=0", pending); end
  endtask

  task automatic test_raw();
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    idle();
    src1_addr = 5'd7;
    #1;
    total++; if (pending !== 32'h0000_0080) begin bad++; $display("FAIL raw_pending_set got=%h exp=80", pending); end
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL raw_hazard_src1 got=%b exp=1", hazard_stall); end
    src1_addr = 5'd0; src2_addr = 5'd7;
    #1;
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL raw_hazard_src2 got=%b exp=1", hazard_stall); end
    src2_addr = 5'd6;
    #1;
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL raw_no_hazard got=%b exp=0", hazard_stall); end
    src1_addr = 5'd7; src2_addr = 5'd0;
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h55;
    #1;
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL raw_ll_ready got=%b exp=1", ll_ready); end
    step();
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
    #1;
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL raw_pending_clr got=%h exp=0", pending); end
    total++; if (w_reg_addr !== 5'd7 || w_data !== 32'h55 || RegWrite !== 1'b1) begin
      bad++; $display("FAIL raw_ll_write got=%0d/%h/%b exp=7/55/1", w_reg_addr, w_data, RegWrite);
    end
`ifdef WB_BYPASS_EN
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL raw_byp_hazard got=%b exp=0", hazard_stall); end
    total++; if (byp1_hit !== 1'b1) begin bad++; $display("FAIL raw_byp1_hit got=%b exp=1", byp1_hit); end
    total++; if (byp2_hit !== 1'b0) begin bad++; $display("FAIL raw_byp2_hit got=%b exp=0", byp2_hit); end
    total++; if (byp_data !== 32'h55) begin bad++; $display("FAIL raw_byp_data got=%h exp=55", byp_data); end
`else
    total++; if (hazard_stall !== 1'b1) begin bad++; $display("FAIL raw_bubble got=%b exp=1", hazard_stall); end
`endif
    step();
    total++; if (hazard_stall !== 1'b0) begin bad++; $display("FAIL raw_release got=%b exp=0", hazard_stall); end
    idle();
  endtask

  task automatic test_starve();
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'h3333_3333;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9999_9999;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ll_ready !== 1'b0 || pipe_stall !== 1'b0) begin
        bad++; $display("FAIL starve_wait%0d got=%b/%b exp=0/0", i, ll_ready, pipe_stall);
      end
      step();
    end
    #1;
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL starve_ll_ready got=%b exp=1", ll_ready); end
    total++; if (pipe_stall !== 1'b1) begin bad++; $display("FAIL starve_pipe_stall got=%b exp=1", pipe_stall); end
    step();
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
    #1;
    total++; if (w_reg_addr !== 5'd9 || w_data !== 32'h9999_9999 || RegWrite !== 1'b1) begin
      bad++; $display("FAIL starve_ll_write got=%0d/%h/%b exp=9/99999999/1", w_reg_addr, w_data, RegWrite);
    end
    total++; if (pipe_stall !== 1'b0) begin bad++; $display("FAIL starve_pipe_resume got=%b exp=0", pipe_stall); end
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL starve_pending got=%h exp=0", pending); end
    step();
    idle();
    // counter must have restarted: a fresh ll request loses to the pipeline
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd2; pipe_wb_data = 32'h2;
    ll_valid = 1'b1; ll_rd = 5'd9; ll_data = 32'h9;
    #1;
    total++; if (w_reg_addr !== 5'd3 || w_data !== 32'h3333_3333 || RegWrite !== 1'b1) begin
      bad++; $display("FAIL starve_pipe_write got=%0d/%h/%b exp=3/33333333/1", w_reg_addr, w_data, RegWrite);
    end
    total++; if (ll_ready !== 1'b0) begin bad++; $display("FAIL starve_cnt_clear got=%b exp=0", ll_ready); end
    step();
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd10; pipe_wb_data = 32'hA0;
    ll_valid = 1'b1; ll_rd = 5'd11; ll_data = 32'hB0;
    step();
    pipe_wb_valid = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
    #1;
    total++; if (w_reg_addr !== 5'd10 || w_data !== 32'hA0) begin
      bad++; $display("FAIL b2b_pipe_first got=%0d/%h exp=10/a0", w_reg_addr, w_data);
    end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL b2b_ll_ready got=%b exp=1", ll_ready); end
    step();
    idle();
    #1;
    total++; if (w_reg_addr !== 5'd11 || w_data !== 32'hB0 || RegWrite !== 1'b1) begin
      bad++; $display("FAIL b2b_ll_second got=%0d/%h/%b exp=11/b0/1", w_reg_addr, w_data, RegWrite);
    end
    step();
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_rd = 5'd4;
    step();
    #1;
    total++; if (pending !== 32'h0000_0010) begin bad++; $display("FAIL waw_pending_set got=%h exp=10", pending); end
    total++; if (issue_stall !== 1'b1) begin bad++; $display("FAIL waw_issue_stall got=%b exp=1", issue_stall); end
    issue_valid = 1'b0; issue_rd = '0;
    ll_valid = 1'b1; ll_rd = 5'd4; ll_data = 32'h44;
    step();
    ll_valid = 1'b0; ll_rd = '0; ll_data = '0;
    #1;
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL waw_pending_clr got=%h exp=0", pending); end
    issue_valid = 1'b1; issue_rd = 5'd4;
    ll_valid = 1'b1; ll_rd = 5'd4; ll_data = 32'h45;
    #1;
    total++; if (issue_stall !== 1'b0) begin bad++; $display("FAIL waw_same_issue_stall got=%b exp=0", issue_stall); end
    total++; if (ll_ready !== 1'b1) begin bad++; $display("FAIL waw_same_ll_ready got=%b exp=1", ll_ready); end
    step();
    idle();
    #1;
    total++; if (pending !== 32'h0000_0010) begin bad++; $display("FAIL waw_set_wins got=%h exp=10", pending); end
    total++; if (w_reg_addr !== 5'd4 || w_data !== 32'h45) begin
      bad++; $display("FAIL waw_ll_write got=%0d/%h exp=4/45", w_reg_addr, w_data);
    end
    ll_valid = 1'b1; ll_rd = 5'd4; ll_data = 32'h46;
    step();
    idle();
    #1;
    total++; if (pending !== 32'h0) begin bad++; $display("FAIL waw_final_clr got=%h exp=0", pending); end
    step();
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_x0();
    test_raw();
    test_starve();
    test_back_to_back();
    test_waw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
